// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Purpose  : 8N1 asynchronous serial receiver. Resynchronises the rx line,
//             detects a start edge, checks it at mid start bit, then takes one
//             mid-bit sample for each of 8 data bits (LSB first) and the stop
//             bit. A good stop bit publishes the byte; a bad one flags a
//             framing error and disarms the receiver until the line idles
//             high again.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous reset, active low
//             ce        - clock enable; low freezes FSM, counters, shifter
//             rx        - asynchronous serial line, idles high
//             rx_byte   - last good byte, held until the next good frame
//             byte_dv   - one-cycle pulse when rx_byte is updated
//             frame_err - one-cycle pulse when the stop bit samples low
//             busy      - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_dv,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    // Terminal counts. The counter starts at 0 in the cycle after the
    // transition, so the sample falls H (or N) enabled cycles later.
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    rx_byte_nxt;
    logic          armed, armed_nxt;
    logic          dv_nxt;
    logic          fe_nxt;
    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchroniser, free running so the line is tracked even while
    // ce is low. Preset to idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        rx_byte_nxt = rx_byte;
        armed_nxt   = armed;
        dv_nxt      = 1'b0;
        fe_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                // After a framing error (break / stuck-low line) the line
                // must be seen high before a new start edge is accepted.
                if (rx_s) begin
                    armed_nxt = 1'b1;
                end
                if (armed && !rx_s) begin
                    state_nxt = ST_START;
                    cnt_nxt   = '0;
                end
            end

            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_DATA;
                        bit_idx_nxt = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    // LSB arrives first: shift right, new sample into MSB.
                    shift_nxt = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    // Back to idle at mid stop bit so a back-to-back start
                    // edge half a bit later is still caught.
                    state_nxt = ST_IDLE;
                    if (rx_s) begin
                        rx_byte_nxt = shift;
                        dv_nxt      = 1'b1;
                    end else begin
                        fe_nxt    = 1'b1;
                        armed_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_byte   <= 8'h00;
            armed     <= 1'b0;
            byte_dv   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Pulses are cleared on every clock, independent of ce, so they
            // never last more than one cycle.
            byte_dv   <= ce & dv_nxt;
            frame_err <= ce & fe_nxt;
            if (ce) begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                bit_idx <= bit_idx_nxt;
                shift   <= shift_nxt;
                rx_byte <= rx_byte_nxt;
                armed   <= armed_nxt;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_byte
//  Purpose  : Self-checking bench for uart_rx_byte (CLKS_PER_BIT = 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int N   = 16;
    localparam int H   = N / 2;
    // Line fall -> two synchroniser flops -> T0, then byte_dv in T0+H+9N+1.
    localparam int LAT = 2 + H + 9 * N + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce  = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_byte;
    logic       byte_dv;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_dv   (byte_dv),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- output event log ----------------
    typedef struct {
        bit         is_err;
        logic [7:0] val;
        int         cyc;
    } ev_t;

    ev_t  ev_q[$];
    int   pulse_viol = 0;
    logic prev_dv = 1'b0;
    logic prev_fe = 1'b0;

    always @(negedge clk) begin
        if (byte_dv)   ev_q.push_back('{1'b0, rx_byte, cyc});
        if (frame_err) ev_q.push_back('{1'b1, rx_byte, cyc});
        if ((byte_dv && (prev_dv || frame_err)) || (frame_err && prev_fe))
            pulse_viol++;
        prev_dv = byte_dv;
        prev_fe = frame_err;
    end

    // ---------------- line driver ----------------
    task automatic tick(input logic lvl, input logic ce_v);
        @(posedge clk);
        #1;
        rx = lvl;
        ce = ce_v;
    endtask

    // One line bit of N enabled cycles; optional random ce=0 cycles, or a
    // block of hold_len ce=0 cycles in the middle of the bit.
    task automatic send_bit(input logic lvl, input bit rand_ce, input int hold_len,
                            output int first);
        first = -1;
        for (int k = 0; k < N; k++) begin
            if (rand_ce)
                while ($urandom_range(0, 7) == 0) begin
                    tick(lvl, 1'b0);
                    if (first < 0) first = cyc;
                end
            if (hold_len > 0 && k == H)
                repeat (hold_len) tick(lvl, 1'b0);
            tick(lvl, 1'b1);
            if (first < 0) first = cyc;
        end
    endtask

    task automatic send_idle(input int n, input bit rand_ce);
        int unused;
        for (int k = 0; k < n; k++) begin
            if (rand_ce && $urandom_range(0, 7) == 0) tick(1'b1, 1'b0);
            tick(1'b1, 1'b1);
        end
        unused = 0;
    endtask

    int fall_q[$];

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                              input int hold_bit, input int hold_len, input bit rand_ce);
        logic lvl;
        int   f;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = stop;
            else             lvl = d[b-1];
            send_bit(lvl, rand_ce, (b == hold_bit) ? hold_len : 0, f);
            if (b == 0) fall_q.push_back(f);
        end
        send_idle(gap, rand_ce);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        bit         exp_err;
        logic [7:0] exp_val;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   tf;
        int   busy_hits;
        int   f;
        logic [7:0] last_good;
        ev_t  exp_q[$];

        vecs[0] = '{8'hA5, 1'b1, 3, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};   // back-to-back with next
        vecs[2] = '{8'hFF, 1'b1, 5, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, N, 1'b1, 8'hFF};   // bad stop: byte held
        vecs[4] = '{8'h11, 1'b1, 2, 1'b0, 8'h11};
        vecs[5] = '{8'h5A, 1'b1, 0, 1'b0, 8'h5A};
        vecs[6] = '{8'hC3, 1'b1, 4, 1'b0, 8'hC3};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_byte", {24'h0, rx_byte}, 32'h00);
        check("rst_byte_dv", {31'h0, byte_dv}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        send_idle(5, 1'b0);

        // ---- table-driven frames, ce=1 ----
        ev_q.delete();
        fall_q.delete();
        foreach (vecs[i]) send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, -1, 0, 1'b0);
        send_idle(2 * N, 1'b0);
        check("tbl_event_count", ev_q.size(), 7);
        foreach (vecs[i]) begin
            if (i < ev_q.size()) begin
                check($sformatf("tbl%0d_kind", i), {31'h0, ev_q[i].is_err}, {31'h0, vecs[i].exp_err});
                check($sformatf("tbl%0d_byte", i), {24'h0, ev_q[i].val}, {24'h0, vecs[i].exp_val});
                check($sformatf("tbl%0d_latency", i), ev_q[i].cyc, fall_q[i] + LAT);
            end
        end

        // ---- short glitch, then a real frame ----
        ev_q.delete();
        tick(1'b0, 1'b1);
        tf = cyc;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        while (cyc < tf + 10) tick(1'b1, 1'b1);
        check("glitch_busy_at_T0+8", {31'h0, busy}, 32'h1);
        tick(1'b1, 1'b1);
        check("glitch_busy_at_T0+9", {31'h0, busy}, 32'h0);
        send_idle(N, 1'b0);
        check("glitch_no_event", ev_q.size(), 0);
        send_frame(8'h5A, 1'b1, 2 * N, -1, 0, 1'b0);
        check("glitch_next_count", ev_q.size(), 1);
        if (ev_q.size() > 0) check("glitch_next_byte", {24'h0, ev_q[0].val}, 32'h5A);

        // ---- bad stop followed by a long break ----
        ev_q.delete();
        send_frame(8'h3C, 1'b0, 0, -1, 0, 1'b0);
        busy_hits = 0;
        repeat (40 * N) begin
            tick(1'b0, 1'b1);
            if (busy) busy_hits++;
        end
        check("break_busy_cycles", busy_hits, 0);
        check("break_events", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check("break_is_err", {31'h0, ev_q[0].is_err}, 32'h1);
            check("break_byte_held", {24'h0, ev_q[0].val}, 32'h5A);
        end
        send_idle(N, 1'b0);
        send_frame(8'h11, 1'b1, 2 * N, -1, 0, 1'b0);
        check("after_break_count", ev_q.size(), 2);
        if (ev_q.size() > 1) check("after_break_byte", {24'h0, ev_q[1].val}, 32'h11);

        // ---- ce low for 20 cycles in the middle of data bit 3 ----
        ev_q.delete();
        fall_q.delete();
        send_frame(8'h96, 1'b1, 2 * N, 4, 20, 1'b0);
        check("ce_hold_count", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            check("ce_hold_byte", {24'h0, ev_q[0].val}, 32'h96);
            check("ce_hold_latency", ev_q[0].cyc, fall_q[0] + LAT + 20);
        end

        // ---- reset in the middle of a frame ----
        ev_q.delete();
        send_bit(1'b0, 1'b0, 0, f);
        send_bit(1'b1, 1'b0, 0, f);
        send_bit(1'b0, 1'b0, 0, f);
        check("midrst_busy_before", {31'h0, busy}, 32'h1);
        #3;
        rst = 1'b0;
        rx  = 1'b1;
        #2;
        check("midrst_rx_byte", {24'h0, rx_byte}, 32'h00);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_pulses", {30'h0, byte_dv, frame_err}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        send_idle(12 * N, 1'b0);
        check("midrst_no_event", ev_q.size(), 0);

        // ---- two bytes assembled low-first into a word ----
        ev_q.delete();
        send_frame(8'h34, 1'b1, 2, -1, 0, 1'b0);
        send_frame(8'h12, 1'b1, 2 * N, -1, 0, 1'b0);
        check("word_count", ev_q.size(), 2);
        if (ev_q.size() > 1) check("word_value", {16'h0, ev_q[1].val, ev_q[0].val}, 32'h1234);

        // ---- randomized frames, random ce gaps, reference model ----
        ev_q.delete();
        exp_q.delete();
        last_good = 8'h12;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? $urandom_range(0, 20) : N + $urandom_range(0, 8);
            // Good stop publishes the byte; bad stop flags and keeps the old one.
            if (stop) begin
                last_good = d;
                exp_q.push_back('{1'b0, d, 0});
            end else begin
                exp_q.push_back('{1'b1, last_good, 0});
            end
            send_frame(d, stop, gap, -1, 0, 1'b1);
        end
        send_idle(2 * N, 1'b0);
        check("rand_event_count", ev_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < ev_q.size()) begin
                check($sformatf("rand%0d_kind", i), {31'h0, ev_q[i].is_err}, {31'h0, exp_q[i].is_err});
                check($sformatf("rand%0d_byte", i), {24'h0, ev_q[i].val}, {24'h0, exp_q[i].val});
            end
        end

        check("pulse_width_violations", pulse_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
